dmem_bytelane: RTL and testbench

Parametrised successor to the single-port MIPS data memory.
- Word-organised RAM with little-endian byte-lane stores (SB/SH/SW) and size-aware loads (LB/LBU/LH/LHU/LW) with sign or zero extension.
- Registered 1-cycle read, a req/ready/rvalid handshake, alignment checking and a post-reset clear sequencer.
- Sits between the MEM pipeline stage and the MEM/WB register.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_lane_align.sv | 60 ++++++
 rtl/dmem_bytelane.sv | 121 ++++++++++++
 tb/tb_dmem_bytelane.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane data memory: access size codes, FSM states,
// and the byte-enable helper used by the lane aligner.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // Lane mask for an access; alignment legality is judged separately.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store-side replication, byte enables and legality check,
// plus load-side lane extraction with sign/zero extension. Zero latency, no flow control.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_lane,
    input  logic [31:0] wdata,
    output logic [31:0] wdata_lanes,
    output logic [3:0]  be,
    output logic        illegal,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_lane,
    input  logic        ld_sext,
    input  logic [31:0] rword,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        case (st_size)
            SZ_BYTE: illegal = 1'b0;
            SZ_HALF: illegal = st_lane[0];
            SZ_WORD: illegal = (st_lane != 2'b00);
            default: illegal = 1'b1;
        endcase
    end

    // Replicating the datum into every lane lets the byte enables alone pick the target.
    always_comb begin
        case (st_size)
            SZ_BYTE: wdata_lanes = {4{wdata[7:0]}};
            SZ_HALF: wdata_lanes = {2{wdata[15:0]}};
            default: wdata_lanes = wdata;
        endcase
    end

    assign be = illegal ? 4'b0000 : byte_en(st_size, st_lane);

    always_comb begin
        case (ld_lane)
            2'd0:    ld_byte = rword[7:0];
            2'd1:    ld_byte = rword[15:8];
            2'd2:    ld_byte = rword[23:16];
            default: ld_byte = rword[31:24];
        endcase
        ld_half = ld_lane[1] ? rword[31:16] : rword[15:0];
    end

    always_comb begin
        case (ld_size)
            SZ_BYTE: ld_data = {{24{ld_sext & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = {{16{ld_sext & ld_half[15]}}, ld_half};
            default: ld_data = rword;
        endcase
    end

endmodule

// File: rtl/dmem_bytelane.sv
// Word-organised data memory with byte-lane stores and size-aware loads; optional post-reset clear.
// Latency: one cycle from accept to rvalid. Backpressure: ready low only during the clear sweep.
module dmem_bytelane
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic                  ready,
    output logic                  rvalid,
    output logic [31:0]           rdata,
    output logic                  misalign
);

    localparam int WIDX  = ADDR_WIDTH - 2;
    localparam int DEPTH = 2 ** WIDX;
    localparam state_e RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;

    logic [31:0]     mem [DEPTH];
    state_e          state;
    state_e          state_nxt;
    logic [WIDX-1:0] clr_ptr;
    logic            ready_q;
    logic            rvalid_q;
    logic            misalign_q;
    logic            ld_q;
    logic [1:0]      ld_size;
    logic [1:0]      ld_lane;
    logic            ld_sext;
    logic [31:0]     rd_word;

    logic            accept;
    logic [WIDX-1:0] widx;
    logic [31:0]     wdata_lanes;
    logic [3:0]      be;
    logic            illegal;
    logic [31:0]     ld_data;

    assign accept = req & ready_q;
    assign widx   = addr[ADDR_WIDTH-1:2];

    dmem_lane_align u_align (
        .st_size     (size),
        .st_lane     (addr[1:0]),
        .wdata       (wdata),
        .wdata_lanes (wdata_lanes),
        .be          (be),
        .illegal     (illegal),
        .ld_size     (ld_size),
        .ld_lane     (ld_lane),
        .ld_sext     (ld_sext),
        .rword       (rd_word),
        .ld_data     (ld_data)
    );

    always_comb begin
        state_nxt = state;
        if (state == ST_CLEAR && clr_ptr == WIDX'(DEPTH - 1)) begin
            state_nxt = ST_READY;
        end
    end

    // ready tracks the next state so it rises on the same edge that ends the clear sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RST_STATE;
            ready_q    <= 1'b0;
            clr_ptr    <= '0;
            rvalid_q   <= 1'b0;
            misalign_q <= 1'b0;
            ld_q       <= 1'b0;
            ld_size    <= SZ_BYTE;
            ld_lane    <= 2'b00;
            ld_sext    <= 1'b0;
        end else begin
            state      <= state_nxt;
            ready_q    <= (state_nxt == ST_READY);
            if (state == ST_CLEAR) begin
                clr_ptr <= clr_ptr + WIDX'(1);
            end
            rvalid_q   <= accept;
            misalign_q <= accept & illegal;
            ld_q       <= accept & ~we & ~illegal;
            if (accept) begin
                ld_size <= size;
                ld_lane <= addr[1:0];
                ld_sext <= sign_ext;
            end
        end
    end

    // Storage is never reset; the rst_n gate keeps a held reset from sweeping word 0.
    always_ff @(posedge clk) begin
        if (rst_n && state == ST_CLEAR) begin
            mem[clr_ptr] <= 32'h0;
        end else if (accept && we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= wdata_lanes[8*i +: 8];
                end
            end
        end
        if (accept && !we) begin
            rd_word <= mem[widx];
        end
    end

    assign ready    = ready_q;
    assign rvalid   = rvalid_q;
    assign misalign = misalign_q;
    assign rdata    = ld_q ? ld_data : 32'h0;

endmodule

// File: tb/tb_dmem_bytelane.sv
module tb_dmem_bytelane;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sign_ext = 1'b0;
    logic [3:0]  addr = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        misalign;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic        mis;
        logic [31:0] rd;
    } vec_t;

    typedef struct {
        logic        mis;
        logic [31:0] rd;
        int          id;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];

    dmem_bytelane #(.ADDR_WIDTH(4), .CLEAR_ON_RESET(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .we       (we),
        .size     (size),
        .sign_ext (sign_ext),
        .addr     (addr),
        .wdata    (wdata),
        .ready    (ready),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .misalign (misalign)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // Each accepted request must answer on the very next cycle; otherwise outputs are idle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sbq.size() > 0) begin
                exp_t e;
                e = sbq.pop_front();
                checks++;
                if (rvalid !== 1'b1 || misalign !== e.mis || rdata !== e.rd) begin
                    failures++;
                    $display("FAIL resp[%0d]: got rvalid=%b misalign=%b rdata=%h, want rvalid=1 misalign=%b rdata=%h",
                             e.id, rvalid, misalign, rdata, e.mis, e.rd);
                end
            end else begin
                checks++;
                if (rvalid !== 1'b0 || misalign !== 1'b0 || rdata !== 32'h0) begin
                    failures++;
                    $display("FAIL idle: got rvalid=%b misalign=%b rdata=%h, want 0/0/0", rvalid, misalign, rdata);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic void add(input logic w, input logic [1:0] sz, input logic sx, input logic [3:0] a,
                                input logic [31:0] wd, input logic mis, input logic [31:0] rd);
        vec_t v;
        v.we = w; v.size = sz; v.sext = sx; v.addr = a; v.wdata = wd; v.mis = mis; v.rd = rd;
        vecs.push_back(v);
    endfunction

    task automatic issue(input vec_t v, input int id);
        exp_t e;
        req = 1'b1; we = v.we; size = v.size; sign_ext = v.sext; addr = v.addr; wdata = v.wdata;
        @(posedge clk);
        e.mis = v.mis; e.rd = v.rd; e.id = id;
        sbq.push_back(e);
        #1;
    endtask

    task automatic idle();
        req = 1'b0; we = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Counts negedges with ready low after reset release; the sweep must take one cycle per word.
    task automatic wait_clear(input string name);
        int cnt;
        cnt = 0;
        @(negedge clk);
        while (ready !== 1'b1 && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        chk(name, cnt, 4);
    endtask

    initial begin
        // Test 1: clear sweep reads back zero everywhere
        add(0, 2'b10, 0, 4'h0, 32'h0, 0, 32'h0);
        add(0, 2'b10, 0, 4'h4, 32'h0, 0, 32'h0);
        add(0, 2'b10, 0, 4'h8, 32'h0, 0, 32'h0);
        add(0, 2'b10, 0, 4'hC, 32'h0, 0, 32'h0);
        // Test 2: byte merge into a word
        add(1, 2'b10, 0, 4'h4, 32'h8899AABB, 0, 32'h0);
        add(1, 2'b00, 0, 4'h5, 32'hFFFFFF11, 0, 32'h0);
        add(0, 2'b10, 0, 4'h4, 32'h0, 0, 32'h889911BB);
        // Test 3: half store, signed/unsigned loads
        add(1, 2'b01, 0, 4'h6, 32'h1234F00D, 0, 32'h0);
        add(0, 2'b01, 1, 4'h6, 32'h0, 0, 32'hFFFFF00D);
        add(0, 2'b01, 0, 4'h6, 32'h0, 0, 32'h0000F00D);
        add(0, 2'b00, 1, 4'h7, 32'h0, 0, 32'hFFFFFFF0);
        add(0, 2'b00, 0, 4'h5, 32'h0, 0, 32'h00000011);
        add(0, 2'b00, 1, 4'h4, 32'h0, 0, 32'hFFFFFFBB);
        add(0, 2'b01, 0, 4'h4, 32'h0, 0, 32'h000011BB);
        add(0, 2'b10, 1, 4'h4, 32'h0, 0, 32'hF00D11BB);
        // Test 4: rejected requests leave memory alone
        add(1, 2'b10, 0, 4'h0, 32'hDEADBEEF, 0, 32'h0);
        add(1, 2'b10, 0, 4'h2, 32'h12345678, 1, 32'h0);
        add(1, 2'b01, 0, 4'h3, 32'h0000CAFE, 1, 32'h0);
        add(1, 2'b11, 0, 4'h0, 32'hFFFFFFFF, 1, 32'h0);
        add(0, 2'b10, 0, 4'h2, 32'h0, 1, 32'h0);
        add(0, 2'b01, 1, 4'h1, 32'h0, 1, 32'h0);
        add(0, 2'b10, 0, 4'h0, 32'h0, 0, 32'hDEADBEEF);
        // Test 5: store then load back to back
        add(1, 2'b10, 0, 4'h8, 32'h00000001, 0, 32'h0);
        add(0, 2'b10, 0, 4'h8, 32'h0, 0, 32'h00000001);
        // Upper-lane halves and bytes
        add(1, 2'b01, 0, 4'hC, 32'h00008001, 0, 32'h0);
        add(0, 2'b01, 1, 4'hC, 32'h0, 0, 32'hFFFF8001);
        add(0, 2'b00, 0, 4'hD, 32'h0, 0, 32'h00000080);
        add(1, 2'b00, 0, 4'hF, 32'h0000007F, 0, 32'h0);
        add(0, 2'b00, 1, 4'hF, 32'h0, 0, 32'h0000007F);
        add(0, 2'b10, 0, 4'hC, 32'h0, 0, 32'h7F008001);

        #1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("reset_ready", {31'h0, ready}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_clear("clear_cycles");

        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i], i);
        end
        idle();
        idle();
        chk("queue_drained", sbq.size(), 0);

        // Test 6: reset right after a load is accepted drops the response
        req = 1'b1; we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 4'h4;
        @(posedge clk);
        #1 rst_n = 1'b0;
        req = 1'b0;
        @(negedge clk);
        chk("abort_rvalid", {31'h0, rvalid}, 32'h0);
        chk("abort_rdata", rdata, 32'h0);
        chk("abort_ready", {31'h0, ready}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_clear("reclear_cycles");
        begin
            vec_t v;
            v.we = 0; v.size = 2'b10; v.sext = 0; v.addr = 4'h4; v.wdata = 32'h0; v.mis = 0; v.rd = 32'h0;
            issue(v, 100);
            v.addr = 4'h0;
            issue(v, 101);
        end
        idle();
        idle();
        chk("queue_drained_end", sbq.size(), 0);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
